// File: rtl/intp_svc.sv
// Interrupt service sequencer: picks the highest-priority pending source,
// hands its vector to a handler, then pulses a clear back to the manager.
module intp_svc #(
   parameter int SIG_WIDTH = 8,
   parameter int VEC_WIDTH = 3,
   parameter int TMO_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 intp_sig_out,
   input  logic [SIG_WIDTH-1:0] intp_sig_stat,
   input  logic [SIG_WIDTH-1:0] intp_sig_mask,
   input  logic                 svc_en,
   input  logic [TMO_WIDTH-1:0] tmo_limit,
   output logic                 vec_valid,
   output logic [VEC_WIDTH-1:0] vec_id,
   input  logic                 vec_ready,
   input  logic                 svc_done,
   output logic [SIG_WIDTH-1:0] intp_sig_clr,
   output logic                 svc_busy,
   output logic                 tmo_err,
   input  logic                 tmo_err_clr
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PICK    = 3'd1;
   localparam logic [2:0] S_PRESENT = 3'd2;
   localparam logic [2:0] S_SERVICE = 3'd3;
   localparam logic [2:0] S_CLEAR   = 3'd4;
   localparam logic [2:0] S_SETTLE  = 3'd5;

   localparam logic [SIG_WIDTH-1:0] ONE = {{(SIG_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]           state_q;
   logic [2:0]           state_d;
   logic [VEC_WIDTH-1:0] vec_q;
   logic [TMO_WIDTH-1:0] cnt_q;
   logic                 err_q;

   logic [SIG_WIDTH-1:0] pend;
   logic [VEC_WIDTH-1:0] pick_id;
   logic                 pick_any;
   logic                 tmo_hit;
   logic                 hshake;
   logic                 tmo_set;

   assign pend     = intp_sig_stat & ~intp_sig_mask;
   assign pick_any = |pend;

   // Scan downward so the lowest set index is the one left standing.
   always_comb begin
      pick_id = '0;
      for (int i = SIG_WIDTH - 1; i >= 0; i--) begin
         if (pend[i]) pick_id = VEC_WIDTH'(i);
      end
   end

   assign tmo_hit = (tmo_limit != '0) && (cnt_q == tmo_limit);
   assign hshake  = (state_q == S_PRESENT) && vec_ready;
   assign tmo_set = (state_q == S_SERVICE) && !svc_done && tmo_hit;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (svc_en && intp_sig_out) state_d = S_PICK;
         end
         S_PICK: begin
            state_d = pick_any ? S_PRESENT : S_IDLE;
         end
         S_PRESENT: begin
            if (vec_ready) state_d = S_SERVICE;
         end
         S_SERVICE: begin
            if (svc_done || tmo_hit) state_d = S_CLEAR;
         end
         S_CLEAR:  state_d = S_SETTLE;
         S_SETTLE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Vector is latched only in PICK so later mask/status moves are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q <= '0;
      end else if (state_q == S_PICK && pick_any) begin
         vec_q <= pick_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (hshake) begin
         cnt_q <= '0;
      end else if (state_q == S_SERVICE && !svc_done && !tmo_hit) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (tmo_set) begin
         err_q <= 1'b1;
      end else if (tmo_err_clr) begin
         err_q <= 1'b0;
      end
   end

   assign vec_valid    = (state_q == S_PRESENT);
   assign vec_id       = vec_q;
   assign svc_busy     = (state_q != S_IDLE);
   assign tmo_err      = err_q;
   assign intp_sig_clr = (state_q == S_CLEAR) ? (ONE << vec_q) : '0;

endmodule

// File: tb/tb_intp_svc.sv
// Bench for intp_svc: directed scenarios plus randomized services
// checked against a cycle-count model of the service flow.
module tb_intp_svc;

   logic       clk = 1'b0;
   logic       rst;
   logic       intp_sig_out;
   logic [7:0] intp_sig_stat;
   logic [7:0] intp_sig_mask;
   logic       svc_en;
   logic [15:0] tmo_limit;
   logic       vec_valid;
   logic [2:0] vec_id;
   logic       vec_ready;
   logic       svc_done;
   logic [7:0] intp_sig_clr;
   logic       svc_busy;
   logic       tmo_err;
   logic       tmo_err_clr;

   int ncmp = 0;
   int nerr = 0;
   int cyc  = 0;
   bit err_m = 1'b0;

   intp_svc dut (
      .clk(clk), .rst(rst),
      .intp_sig_out(intp_sig_out),
      .intp_sig_stat(intp_sig_stat),
      .intp_sig_mask(intp_sig_mask),
      .svc_en(svc_en),
      .tmo_limit(tmo_limit),
      .vec_valid(vec_valid),
      .vec_id(vec_id),
      .vec_ready(vec_ready),
      .svc_done(svc_done),
      .intp_sig_clr(intp_sig_clr),
      .svc_busy(svc_busy),
      .tmo_err(tmo_err),
      .tmo_err_clr(tmo_err_clr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int lowest(input logic [7:0] p);
      for (int i = 0; i < 8; i++) begin
         if (p[i]) return i;
      end
      return -1;
   endfunction

   // One full service attempt; st_pick is the status seen during PICK.
   task automatic run_svc(input logic [7:0] st, input logic [7:0] st_pick,
                          input logic [7:0] mk, input int rdly,
                          input int ddly, input int lim, input bit rnd_clr);
      int   exp_id;
      int   ex;
      bit   tmo;
      bit   set;
      logic [31:0] oh;
      intp_sig_out  = 1'b1;
      svc_en        = 1'b1;
      intp_sig_stat = st;
      intp_sig_mask = mk;
      tmo_limit     = lim[15:0];
      vec_ready     = 1'b0;
      svc_done      = 1'b0;
      tmo_err_clr   = 1'b0;
      step();
      chk("pick_busy", {31'b0, svc_busy}, 1);
      chk("pick_valid", {31'b0, vec_valid}, 0);
      intp_sig_out  = 1'b0;
      svc_en        = 1'($urandom % 2);
      intp_sig_stat = st_pick;
      exp_id = lowest(st_pick & ~mk);
      step();
      if (exp_id < 0) begin
         chk("race_busy", {31'b0, svc_busy}, 0);
         chk("race_valid", {31'b0, vec_valid}, 0);
         return;
      end
      chk("present_valid", {31'b0, vec_valid}, 1);
      chk("present_id", {29'b0, vec_id}, exp_id);
      intp_sig_mask = 8'($urandom);
      intp_sig_stat = 8'($urandom);
      for (int i = 0; i < rdly; i++) begin
         svc_done = 1'($urandom % 2);
         step();
         chk("bp_valid", {31'b0, vec_valid}, 1);
         chk("bp_id", {29'b0, vec_id}, exp_id);
         chk("bp_clr", {24'b0, intp_sig_clr}, 0);
      end
      vec_ready = 1'b1;
      step();
      vec_ready = 1'b0;
      chk("svc_valid", {31'b0, vec_valid}, 0);
      chk("svc_busy", {31'b0, svc_busy}, 1);
      tmo = (lim != 0) && (lim < ddly);
      ex  = tmo ? lim : ddly;
      oh  = 32'd1 << exp_id;
      for (int idx = 0; idx <= ex; idx++) begin
         svc_done    = (idx == ddly);
         tmo_err_clr = rnd_clr ? 1'($urandom % 2) : 1'b0;
         set = tmo && (idx == ex);
         if (set) err_m = 1'b1;
         else if (tmo_err_clr) err_m = 1'b0;
         step();
         chk("svc_err", {31'b0, tmo_err}, {31'b0, err_m});
         if (idx == ex) chk("clr_pulse", {24'b0, intp_sig_clr}, oh);
         else chk("svc_noclr", {24'b0, intp_sig_clr}, 0);
      end
      svc_done    = 1'b0;
      tmo_err_clr = 1'b0;
      step();
      chk("settle_clr", {24'b0, intp_sig_clr}, 0);
      chk("settle_busy", {31'b0, svc_busy}, 1);
      step();
      chk("idle_busy", {31'b0, svc_busy}, 0);
      chk("idle_valid", {31'b0, vec_valid}, 0);
   endtask

   initial begin
      int c0;
      logic [7:0] s;
      rst = 1'b1;
      intp_sig_out = 1'b0;
      intp_sig_stat = 8'h00;
      intp_sig_mask = 8'h00;
      svc_en = 1'b0;
      tmo_limit = 16'd0;
      vec_ready = 1'b0;
      svc_done = 1'b0;
      tmo_err_clr = 1'b0;
      step();
      step();
      chk("rst_valid", {31'b0, vec_valid}, 0);
      chk("rst_id", {29'b0, vec_id}, 0);
      chk("rst_clr", {24'b0, intp_sig_clr}, 0);
      chk("rst_busy", {31'b0, svc_busy}, 0);
      chk("rst_err", {31'b0, tmo_err}, 0);
      rst = 1'b0;
      step();

      intp_sig_out = 1'b1;
      svc_en = 1'b0;
      step();
      chk("en_off_busy", {31'b0, svc_busy}, 0);
      intp_sig_out = 1'b0;
      step();

      c0 = cyc;
      run_svc(8'h10, 8'h10, 8'h00, 0, 0, 0, 1'b0);
      chk("min_period", cyc - c0, 6);

      run_svc(8'h2C, 8'h2C, 8'h04, 0, 1, 0, 1'b0);
      run_svc(8'h24, 8'h24, 8'h04, 1, 0, 0, 1'b0);

      run_svc(8'h40, 8'h40, 8'h00, 10, 2, 0, 1'b0);

      run_svc(8'h02, 8'h02, 8'h00, 0, 1000, 3, 1'b0);
      chk("tmo_sticky", {31'b0, tmo_err}, 1);
      tmo_err_clr = 1'b1;
      step();
      tmo_err_clr = 1'b0;
      err_m = 1'b0;
      chk("tmo_cleared", {31'b0, tmo_err}, 0);

      run_svc(8'h08, 8'h00, 8'h00, 0, 0, 0, 1'b0);
      run_svc(8'h01, 8'h01, 8'h00, 0, 2, 2, 1'b0);
      chk("coincide_err", {31'b0, tmo_err}, 0);

      intp_sig_out = 1'b1;
      svc_en = 1'b1;
      intp_sig_stat = 8'h80;
      intp_sig_mask = 8'h00;
      tmo_limit = 16'd0;
      step();
      intp_sig_out = 1'b0;
      step();
      vec_ready = 1'b1;
      step();
      vec_ready = 1'b0;
      chk("mid_busy", {31'b0, svc_busy}, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", {31'b0, svc_busy}, 0);
      chk("mid_rst_id", {29'b0, vec_id}, 0);
      chk("mid_rst_clr", {24'b0, intp_sig_clr}, 0);
      chk("mid_rst_valid", {31'b0, vec_valid}, 0);
      svc_done = 1'b1;
      step();
      chk("mid_rst_noclr", {24'b0, intp_sig_clr}, 0);
      svc_done = 1'b0;
      rst = 1'b0;
      err_m = 1'b0;
      step();
      chk("post_rst_clr", {24'b0, intp_sig_clr}, 0);
      chk("post_rst_busy", {31'b0, svc_busy}, 0);

      for (int t = 0; t < 40; t++) begin
         s = 8'($urandom);
         run_svc(s, ($urandom % 8 == 0) ? 8'h00 : s, 8'($urandom),
                 int'($urandom % 5), int'($urandom % 7),
                 int'($urandom % 6), 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/intp_svc.md
# intp_svc

Interrupt service sequencer that sits on the consumer side of the interrupt manager. It watches the aggregated interrupt line and the per-source status vector, and selects the highest-priority pending unmasked source. It presents that source's vector number to a handler through a valid/ready handshake, waits for the handler to finish (with an optional timeout), and then issues a one-cycle clear pulse back to the manager for that source.

## Interface
- SIG_WIDTH, 8, number of interrupt sources.
- VEC_WIDTH, 3, width of the vector number; 2**VEC_WIDTH >= SIG_WIDTH is required.
- TMO_WIDTH, 16, width of the service timeout counter and limit.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- intp_sig_out  input  1  aggregated interrupt from the manager.
- intp_sig_stat  input  SIG_WIDTH  per-source pending status from the manager.
- intp_sig_mask  input  SIG_WIDTH  per-source mask; 1 = masked. Same value as fed to the manager.
- svc_en  input  1  enables starting a new service; sampled only in IDLE.
- tmo_limit  input  TMO_WIDTH  service timeout in cycles; 0 disables the timeout.
- vec_valid  output  1  vector number is offered to the handler.
- vec_id  output  VEC_WIDTH  vector number of the source being serviced.
- vec_ready  input  1  handler accepts the vector.
- svc_done  input  1  handler finished; single-cycle or level.
- intp_sig_clr  output  SIG_WIDTH  one-hot clear pulse to the manager.
- svc_busy  output  1  high whenever the FSM is not in IDLE.
- tmo_err  output  1  sticky timeout flag.
- tmo_err_clr  input  1  clears tmo_err.

## Operation
- FSM states: IDLE, PICK, PRESENT, SERVICE, CLEAR, SETTLE.
- IDLE: if svc_en && intp_sig_out, go to PICK. Otherwise stay.
- PICK: compute pend = intp_sig_stat & ~intp_sig_mask.
  - If pend == 0 (status raced away), return to IDLE.
  - Otherwise register vec_id = index of the lowest set bit of pend (lowest index = highest priority), then go to PRESENT.
- PRESENT: vec_valid = 1.
  - vec_id is held stable while vec_valid is high.
  - A handshake occurs when vec_valid && vec_ready. On handshake, go to SERVICE and zero the timeout counter.
  - svc_done is ignored in this state.
- SERVICE:
  - If svc_done = 1, go to CLEAR.
  - Else if tmo_limit != 0 and cnt == tmo_limit, set tmo_err and go to CLEAR.
  - Else cnt++.
  - When svc_done and the timeout coincide, svc_done wins and tmo_err is not set.
- CLEAR: intp_sig_clr = one-hot(vec_id) for exactly this cycle, then go to SETTLE.
- SETTLE: one idle cycle so the manager's registered status reflects the clear; then go to IDLE.
- A level-mode source that is still active re-sets its status in the manager. It is then serviced again through the normal flow; this is not an error.
- svc_en deassertion does not abort an in-progress service.
- Masks and status are sampled only in PICK. Mask changes after PICK do not affect the current vector.
- tmo_err: set in SERVICE on timeout. tmo_err_clr clears it. If set and clear happen in the same cycle, set wins.
- vec_id outside PRESENT keeps its last value and is don't-care for the handler.

## Timing
- Reset values: FSM = IDLE, vec_valid = 0, vec_id = 0, intp_sig_clr = 0, svc_busy = 0, tmo_err = 0, cnt = 0.
- Reset asserted mid-service returns to IDLE immediately. No clear pulse is issued.
- All outputs are decoded from registers; there are no combinational paths from inputs to outputs.
- With intp_sig_out high in IDLE at cycle 0: PICK at cycle 1, vec_valid high at cycle 2.
- vec_ready high at cycle k while in PRESENT: SERVICE from k+1, and vec_valid is low at k+1.
- svc_done high at cycle d while in SERVICE: intp_sig_clr pulses at d+1, SETTLE at d+2, IDLE at d+3.
- Minimum period per service, with ready and done both immediate: 6 cycles.
- Timeout: the first SERVICE cycle has cnt = 0. The timeout fires on the (tmo_limit+1)-th SERVICE cycle. tmo_err is visible and intp_sig_clr pulses the next cycle.
- svc_busy = (state != IDLE), registered along with the state.

## Test plan
- Single source: stat = 8'h10, mask = 0, svc_en = 1, ready/done immediate. Expect vec_id = 4 two cycles after intp_sig_out, intp_sig_clr = 8'h10 for one cycle, IDLE 6 cycles after start.
- Priority and mask: stat = 8'h2C, mask = 8'h04. Expect vec_id = 3 first, then vec_id = 5 after the clear; source 2 is never serviced.
- Backpressure: hold vec_ready low for 10 cycles. Expect vec_valid high and vec_id stable throughout, with no clear issued before svc_done.
- Timeout: tmo_limit = 3, svc_done never asserted. Expect tmo_err = 1 after the 4th SERVICE cycle and a clear pulse next. Then assert tmo_err_clr alone and expect tmo_err = 0.
- Race and coincidence: drop stat to 0 during PICK and expect a return to IDLE with no vec_valid. Separately, assert svc_done on the timeout cycle and expect tmo_err to stay 0.
- Reset mid-SERVICE: assert rst. Expect all outputs at reset values immediately and no intp_sig_clr pulse.
